// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer that owns the PC and gates architectural writes.
// Optional performance counters are built when INSTR_SEQ_PERF_CNT_EN is defined.
module instr_sequencer #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             dec_jump_en,
  input  logic             dec_branch_en,
  input  logic             alu_branch_taken,
  input  logic             dec_mem_to_reg,
  input  logic             dec_reg_to_mem,
  input  logic             dec_reg_wr_en,
  input  logic             dec_done,
  input  logic [PC_W-1:0]  jump_target,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             wb_strobe,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_d;
  logic              imem_req_d, dmem_req_d, dmem_we_d, wb_strobe_d, halted_d;
  logic              take_target;

  // The only combinational output: IR capture in the acked fetch cycle.
  assign ir_load = (state_q == S_FETCH) && imem_ack;

  assign take_target = dec_jump_en || (dec_branch_en && alu_branch_taken);

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    imem_req_d  = 1'b0;
    dmem_req_d  = 1'b0;
    dmem_we_d   = 1'b0;
    wb_strobe_d = 1'b0;
    halted_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_done)                             state_d = S_HALT;
        else if (dec_mem_to_reg || dec_reg_to_mem) state_d = S_MEM;
        else                                      state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase

    // PC advances as WB is entered so the new value is visible alongside wb_strobe.
    if (state_d == S_WB) begin
      pc_d = take_target ? jump_target : pc + PC_W'(1);
    end

    imem_req_d  = (state_d == S_FETCH);
    dmem_req_d  = (state_d == S_MEM);
    // Hold the write qualifier for the whole pending data request.
    dmem_we_d   = (state_d == S_MEM) && ((state_q == S_MEM) ? dmem_we : dec_reg_to_mem);
    wb_strobe_d = (state_d == S_WB) && dec_reg_wr_en;
    halted_d    = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc        <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      wb_strobe <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      imem_req  <= imem_req_d;
      dmem_req  <= dmem_req_d;
      dmem_we   <= dmem_we_d;
      wb_strobe <= wb_strobe_d;
      halted    <= halted_d;
    end
  end

`ifdef INSTR_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, cycle_cnt_q;
  logic             restart, retire, active_next;

  assign restart     = ((state_q == S_IDLE) || (state_q == S_HALT)) && start;
  assign retire      = (state_q == S_WB) || ((state_q == S_EXEC) && dec_done);
  assign active_next = (state_d == S_FETCH) || (state_d == S_EXEC) ||
                       (state_d == S_MEM)   || (state_d == S_WB);

  // Saturating counters; the start edge clears them and enters the first counted cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else if (restart) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (retire && (instr_cnt_q != {CNT_W{1'b1}}))
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      if (active_next && (cycle_cnt_q != {CNT_W{1'b1}}))
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
`else
  assign instr_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule
